// File: rtl/keypad_digit_decoder_pkg.sv
// ============================================================================
// keypad_digit_decoder_pkg - shared FSM encoding and 7-segment glyph table
// Revision: 1.0
// ============================================================================
`default_nettype none

package keypad_digit_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kdd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_digit_decoder_bcd_to_7seg.sv
// ============================================================================
// bcd_to_7seg - combinational BCD digit to active-low 7-segment decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_7seg
  import keypad_digit_decoder_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_pattern(digit_i);

endmodule

`default_nettype wire

// File: rtl/keypad_digit_decoder.sv
// ============================================================================
// keypad_digit_decoder - debounced keypad to 4-digit BCD entry and 7-seg mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_digit_decoder
  import keypad_digit_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REFRESH_DIV     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D,
  input  logic        V,
  input  logic        clr,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic        key_err,
  output logic [15:0] value,
  output logic [2:0]  digit_count,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int          RW       = $clog2(REFRESH_DIV);
  localparam logic [8:0]  DEB      = 9'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam bit          SINGLE   = (DEBOUNCE_CYCLES <= 1);

  logic        v_meta_q, v_sync_q;
  logic [3:0]  d_meta_q, d_sync_q;
  kdd_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        accept;
  logic [8:0]  run_len, rel_len;

  logic        strobe_q, strobe_d, err_q, err_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] value_q, value_d;
  logic [2:0]  count_q, count_d;

  logic [RW-1:0] rc_q, rc_d;
  logic [1:0]    slot_q, slot_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit_sel;
  logic          blank_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_meta_q <= 1'b0;
      v_sync_q <= 1'b0;
      d_meta_q <= 4'd0;
      d_sync_q <= 4'd0;
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      cand_q   <= 4'd0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 4'd0;
      value_q  <= 16'h0000;
      count_q  <= 3'd0;
      rc_q     <= '0;
      slot_q   <= 2'd0;
      seg_q    <= SEG_BLANK;
    end else begin
      v_meta_q <= V;
      v_sync_q <= v_meta_q;
      d_meta_q <= D;
      d_sync_q <= d_meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      code_q   <= code_d;
      value_q  <= value_d;
      count_q  <= count_d;
      rc_q     <= rc_d;
      slot_q   <= slot_d;
      seg_q    <= seg_d;
    end
  end

  // A changed code restarts the stable-sample run at one.
  assign run_len = (d_sync_q == cand_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
  assign rel_len = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (v_sync_q) begin
          cand_d = d_sync_q;
          cnt_d  = 8'd1;
          if (SINGLE) begin
            accept  = 1'b1;
            state_d = ST_HELD;
          end else begin
            state_d = ST_PRESS_WAIT;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!v_sync_q) begin
          state_d = ST_IDLE;
        end else begin
          cand_d = d_sync_q;
          if (run_len >= DEB) begin
            accept  = 1'b1;
            state_d = ST_HELD;
          end else begin
            cnt_d = run_len[7:0];
          end
        end
      end
      ST_HELD: begin
        if (!v_sync_q) begin
          cnt_d   = 8'd1;
          state_d = SINGLE ? ST_IDLE : ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (v_sync_q) begin
          state_d = ST_HELD;
        end else if (rel_len >= DEB) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = rel_len[7:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    strobe_d = accept;
    err_d    = accept && (cand_d > 4'd9);
    code_d   = accept ? cand_d : code_q;
    value_d  = value_q;
    count_d  = count_q;
    if (clr) begin
      value_d = 16'h0000;
      count_d = 3'd0;
    end else if (accept && (cand_d <= 4'd9)) begin
      value_d = {value_q[11:0], cand_d};
      if (count_q < 3'd4) count_d = count_q + 3'd1;
    end
  end

  // seg is decoded for the slot being entered so it lines up with an.
  always_comb begin
    rc_d   = rc_q + RW'(1);
    slot_d = slot_q;
    if (rc_q == REF_LAST) begin
      rc_d   = '0;
      slot_d = slot_q + 2'd1;
    end
    digit_sel = value_q[{slot_d, 2'b00} +: 4];
    blank_sel = ({1'b0, slot_d} >= count_q);
  end

  bcd_to_7seg u_bcd_to_7seg (
    .digit_i (digit_sel),
    .blank_i (blank_sel),
    .seg_o   (seg_d)
  );

  assign key_strobe  = strobe_q;
  assign key_code    = code_q;
  assign key_err     = err_q;
  assign value       = value_q;
  assign digit_count = count_q;
  assign seg         = seg_q;
  assign an          = ~(4'b0001 << slot_q);

endmodule

`default_nettype wire
